// File: rtl/ir_pkg.sv
// Shared definitions for the NEC-style IR receive path: decoder states, tick
// windows (10 us ticks) and the nominal timings that ir_encoder transmits.
package ir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_RPT_MARK
    } ir_state_e;

    localparam int WIDTH_BITS    = 11;
    localparam int FRAME_BITS    = 32;
    localparam int TIMEOUT_TICKS = 1100;
    localparam int SYNC_STAGES   = 2;

    localparam int NOM_LEAD_MARK  = 900;
    localparam int NOM_LEAD_SPACE = 450;
    localparam int NOM_RPT_SPACE  = 225;
    localparam int NOM_BIT_MARK   = 56;
    localparam int NOM_ZERO_SPACE = 56;
    localparam int NOM_ONE_SPACE  = 169;

    // Acceptance windows are inclusive and tolerate roughly +/-20 % timing error.
    localparam int LEAD_MARK_MIN  = 700;
    localparam int LEAD_MARK_MAX  = 1100;
    localparam int LEAD_SPACE_MIN = 350;
    localparam int LEAD_SPACE_MAX = 550;
    localparam int RPT_SPACE_MIN  = 180;
    localparam int RPT_SPACE_MAX  = 280;
    localparam int BIT_MARK_MIN   = 40;
    localparam int BIT_MARK_MAX   = 75;
    localparam int ZERO_SPACE_MIN = 40;
    localparam int ZERO_SPACE_MAX = 75;
    localparam int ONE_SPACE_MIN  = 130;
    localparam int ONE_SPACE_MAX  = 210;

    function automatic logic in_window(input logic [WIDTH_BITS-1:0] w,
                                       input int lo, input int hi);
        return (int'(w) >= lo) && (int'(w) <= hi);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronizes the IR envelope, flags mark-start/mark-end edges and measures
// the time since the previous edge in saturating 10 us ticks.
module ir_pulse_timer
    import ir_pkg::*;
#(
    parameter int CLK_DIV    = 250,
    parameter bit MARK_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ir_input,
    output logic                  mark_start,
    output logic                  mark_end,
    output logic [WIDTH_BITS-1:0] width
);
    localparam int              PW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST  = PW'(CLK_DIV - 1);
    localparam logic            SPACE_LEVEL = !MARK_LEVEL;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   level_q;
    logic                   armed_q;
    logic                   mark_now;
    logic                   level_changed;
    logic [PW-1:0]          presc_q, presc_d;
    logic [WIDTH_BITS-1:0]  width_q, width_d;

    assign mark_now      = (sync_q[SYNC_STAGES-1] == MARK_LEVEL);
    assign level_changed = (sync_q[SYNC_STAGES-1] != level_q);
    // A mark already on the line at reset release is not a leader: starts are
    // only honoured once a real space sample has passed the synchronizer.
    assign mark_start    = level_changed && mark_now && armed_q;
    assign mark_end      = level_changed && !mark_now;
    assign width         = width_q;

    always_comb begin
        presc_d = presc_q;
        width_d = width_q;
        if (level_changed) begin
            presc_d = '0;
            width_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (width_q != {WIDTH_BITS{1'b1}}) begin
                width_d = width_q + WIDTH_BITS'(1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= {SYNC_STAGES{SPACE_LEVEL}};
            fill_q  <= '0;
            level_q <= SPACE_LEVEL;
            armed_q <= 1'b0;
            presc_q <= '0;
            width_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ir_input};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            level_q <= sync_q[SYNC_STAGES-1];
            if (fill_q[SYNC_STAGES-1] && !mark_now) begin
                armed_q <= 1'b1;
            end
            presc_q <= presc_d;
            width_q <= width_d;
        end
    end

endmodule

// File: rtl/ir_decoder.sv
// NEC-style IR frame decoder: validates mark/space widths, assembles 32 data
// bits LSB-first and hands each frame out through a valid/ready handshake.
module ir_decoder
    import ir_pkg::*;
#(
    parameter int CLK_DIV    = 250,
    parameter bit MARK_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ir_input,
    output logic [FRAME_BITS-1:0] cmd,
    output logic                  valid,
    input  logic                  ready,
    output logic                  repeat_det,
    output logic                  err,
    output logic                  overrun
);
    logic                  mark_start, mark_end;
    logic [WIDTH_BITS-1:0] width;

    ir_state_e             state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] cmd_q, cmd_d;
    logic                  valid_q, valid_d;
    logic                  rep_q, rep_d;
    logic                  err_q, err_d;
    logic                  ovr_q, ovr_d;
    logic                  frame_done;
    logic                  fail;
    logic                  mark_ok, zero_ok, one_ok;

    ir_pulse_timer #(
        .CLK_DIV    (CLK_DIV),
        .MARK_LEVEL (MARK_LEVEL)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .ir_input   (ir_input),
        .mark_start (mark_start),
        .mark_end   (mark_end),
        .width      (width)
    );

    assign mark_ok = in_window(width, BIT_MARK_MIN, BIT_MARK_MAX);
    assign zero_ok = in_window(width, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
    assign one_ok  = in_window(width, ONE_SPACE_MIN, ONE_SPACE_MAX);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        fail       = 1'b0;
        rep_d      = 1'b0;
        unique case (state_q)
            S_IDLE: if (mark_start) state_d = S_LEAD_MARK;
            S_LEAD_MARK: if (mark_end) begin
                if (in_window(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_d = S_LEAD_SPACE;
                else fail = 1'b1;
            end
            S_LEAD_SPACE: if (mark_start) begin
                if (in_window(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                    state_d   = S_BIT_MARK;
                    bit_cnt_d = '0;
                end else if (in_window(width, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                    state_d = S_RPT_MARK;
                end else begin
                    fail = 1'b1;
                end
            end
            S_BIT_MARK: if (mark_end) begin
                if (mark_ok) state_d = S_BIT_SPACE;
                else fail = 1'b1;
            end
            S_BIT_SPACE: if (mark_start) begin
                if (zero_ok || one_ok) begin
                    // Shift in at the top so the first bit lands in cmd[0].
                    shift_d = {one_ok, shift_q[FRAME_BITS-1:1]};
                    if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                        state_d = S_STOP_MARK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = S_BIT_MARK;
                    end
                end else begin
                    fail = 1'b1;
                end
            end
            S_STOP_MARK: if (mark_end) begin
                if (mark_ok) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    fail = 1'b1;
                end
            end
            S_RPT_MARK: if (mark_end) begin
                if (mark_ok) begin
                    rep_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    fail = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && !mark_start && !mark_end && int'(width) > TIMEOUT_TICKS) begin
            fail = 1'b1;
        end
        if (fail) state_d = S_IDLE;
        err_d = fail;
    end

    always_comb begin
        cmd_d   = cmd_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (frame_done) begin
            if (!valid_q || ready) begin
                cmd_d   = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            cmd_q     <= '0;
            valid_q   <= 1'b0;
            rep_q     <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            cmd_q     <= cmd_d;
            valid_q   <= valid_d;
            rep_q     <= rep_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign cmd        = cmd_q;
    assign valid      = valid_q;
    assign repeat_det = rep_q;
    assign err        = err_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_ir_decoder.sv
// Bench for ir_decoder: an event-level NEC parser predicts every output cycle,
// backed by literal checks for each directed scenario.
module tb_ir_decoder;

    logic        clk;
    logic        rst;
    logic        ir_in;
    logic        ready;
    logic [31:0] cmd;
    logic        valid, repeat_det, err, overrun;

    ir_decoder #(
        .CLK_DIV    (1),
        .MARK_LEVEL (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ir_input   (ir_in),
        .cmd        (cmd),
        .valid      (valid),
        .ready      (ready),
        .repeat_det (repeat_det),
        .err        (err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    localparam logic [1:0] EV_NONE = 2'd0, EV_FRAME = 2'd1, EV_REP = 2'd2, EV_ERR = 2'd3;
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } ev_t;

    // m_pos: 0 idle, 1 leader mark, 2 leader space, 3 repeat mark,
    // 10+2*i mark before bit i (i=32 is the stop mark), 11+2*i space of bit i.
    int          m_pos, m_last, cyc;
    bit          m_armed, m_prev;
    logic [31:0] m_data;
    ev_t         pipe0, pipe1;
    logic [31:0] e_cmd;
    logic        e_valid, e_rep, e_err, e_ovr;

    function automatic bit inw(input int w, input int lo, input int hi);
        return (w >= lo) && (w <= hi);
    endfunction

    task automatic model_step(input bit smp, input int k, output ev_t ev);
        int w;
        int idx;
        bit bad;
        ev  = '0;
        bad = 1'b0;
        if (smp != m_prev) begin
            w = k - m_last - 1;
            if (w > 2047) w = 2047;
            m_last = k;
            m_prev = smp;
            if (m_pos == 0) begin
                if (smp && m_armed) m_pos = 1;
            end else if (m_pos == 1) begin
                if (inw(w, 700, 1100)) m_pos = 2; else bad = 1'b1;
            end else if (m_pos == 2) begin
                if (inw(w, 350, 550)) begin m_pos = 10; m_data = '0; end
                else if (inw(w, 180, 280)) m_pos = 3;
                else bad = 1'b1;
            end else if (m_pos == 3) begin
                if (inw(w, 40, 75)) begin ev.kind = EV_REP; m_pos = 0; end
                else bad = 1'b1;
            end else if (m_pos % 2 == 0) begin
                if (!inw(w, 40, 75)) bad = 1'b1;
                else if (m_pos == 74) begin ev.kind = EV_FRAME; ev.data = m_data; m_pos = 0; end
                else m_pos++;
            end else begin
                idx = (m_pos - 11) / 2;
                if (inw(w, 40, 75)) m_pos++;
                else if (inw(w, 130, 210)) begin m_data[idx] = 1'b1; m_pos++; end
                else bad = 1'b1;
            end
        end else if (m_pos != 0 && k - m_last == 1102) begin
            bad = 1'b1;
        end
        if (bad) begin
            ev.kind = EV_ERR;
            m_pos   = 0;
        end
        if (!smp) m_armed = 1'b1;
    endtask

    // Every cycle: advance the model (decisions surface two clocks later) and
    // compare all outputs just after the edge.
    always @(posedge clk) begin : compare
        ev_t ev;
        cyc++;
        if (!rst) begin
            m_pos = 0; m_armed = 1'b0; m_prev = 1'b0; m_last = cyc; m_data = '0;
            pipe0 = '0; pipe1 = '0;
            e_cmd = '0; e_valid = 1'b0; e_rep = 1'b0; e_err = 1'b0; e_ovr = 1'b0;
        end else begin
            ev    = pipe1;
            pipe1 = pipe0;
            model_step(ir_in, cyc, pipe0);
            e_rep = (ev.kind == EV_REP);
            e_err = (ev.kind == EV_ERR);
            e_ovr = 1'b0;
            if (ev.kind == EV_FRAME) begin
                if (!e_valid || ready) begin
                    e_cmd   = ev.data;
                    e_valid = 1'b1;
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (e_valid && ready) begin
                e_valid = 1'b0;
            end
        end
        #1;
        n_vec++;
        if ({cmd, valid, repeat_det, err, overrun} !== {e_cmd, e_valid, e_rep, e_err, e_ovr}) begin
            n_miss++;
            $display("FAIL outputs cyc %0d: cmd=%h v=%b rep=%b err=%b ovr=%b, expected cmd=%h v=%b rep=%b err=%b ovr=%b",
                     cyc, cmd, valid, repeat_det, err, overrun, e_cmd, e_valid, e_rep, e_err, e_ovr);
        end
    end

    // Observed DUT events, used by the literal scenario checks.
    int          n_take = 0, n_rep = 0, n_errp = 0, n_ovr = 0;
    logic [31:0] last_take = '0;
    int          s_take, s_rep, s_err, s_ovr;

    always @(posedge clk) begin
        if (valid && ready) begin
            n_take++;
            last_take = cmd;
        end
        if (repeat_det) n_rep++;
        if (err) n_errp++;
        if (overrun) n_ovr++;
    end

    task automatic snap();
        s_take = n_take; s_rep = n_rep; s_err = n_errp; s_ovr = n_ovr;
    endtask

    // ---------------- stimulus ----------------
    function automatic int sc(input int n, input int pct);
        return (n * pct + 50) / 100;
    endfunction

    task automatic seg(input bit mark, input int n);
        ir_in = mark;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] d, input int nbits, input int pct);
        seg(1'b1, sc(900, pct));
        seg(1'b0, sc(450, pct));
        for (int i = 0; i < nbits; i++) begin
            seg(1'b1, sc(56, pct));
            seg(1'b0, sc(d[i] ? 169 : 56, pct));
        end
    endtask

    task automatic send_frame(input logic [31:0] d, input int pct);
        send_bits(d, 32, pct);
        seg(1'b1, sc(56, pct));
        seg(1'b0, 300);
    endtask

    task automatic send_repeat(input int pct);
        seg(1'b1, sc(900, pct));
        seg(1'b0, sc(225, pct));
        seg(1'b1, sc(56, pct));
        seg(1'b0, 300);
    endtask

    initial begin
        cyc   = 0;
        rst   = 1'b0;
        ir_in = 1'b0;
        ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_cmd", cmd, 32'h0);
        chk("reset_flags", {29'd0, valid, repeat_det, err | overrun}, 32'h0);
        rst = 1'b1;
        seg(1'b0, 40);

        // Loopback-style frame, consumer always ready.
        snap();
        send_frame(32'hFB040707, 100);
        chk("loop_take", 32'(n_take - s_take), 32'd1);
        chk("loop_cmd", last_take, 32'hFB040707);
        chk("loop_err", 32'(n_errp - s_err), 32'd0);

        // Repeat code leaves cmd/valid alone.
        snap();
        send_repeat(100);
        chk("rpt_pulses", 32'(n_rep - s_rep), 32'd1);
        chk("rpt_valid", {31'd0, valid}, 32'd0);
        chk("rpt_cmd", cmd, 32'hFB040707);

        // Short leader, then a clean frame.
        snap();
        seg(1'b1, 500);
        seg(1'b0, 300);
        chk("badlead_err", 32'(n_errp - s_err), 32'd1);
        snap();
        send_frame(32'h00FF10EF, 100);
        chk("after_bad_cmd", last_take, 32'h00FF10EF);
        chk("after_bad_take", 32'(n_take - s_take), 32'd1);

        // Truncated after 16 bits: only the timeout can end it.
        snap();
        send_bits(32'h0000A5C3, 16, 100);
        seg(1'b1, 56);
        seg(1'b0, 1300);
        chk("trunc_err", 32'(n_errp - s_err), 32'd1);
        chk("trunc_take", 32'(n_take - s_take), 32'd0);

        // Backpressure: second frame must be dropped.
        ready = 1'b0;
        snap();
        send_frame(32'h12345678, 100);
        send_frame(32'hAABBCCDD, 100);
        chk("bp_valid", {31'd0, valid}, 32'd1);
        chk("bp_cmd", cmd, 32'h12345678);
        chk("bp_overrun", 32'(n_ovr - s_ovr), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_valid", {31'd0, valid}, 32'd0);
        chk("bp_drain_cmd", last_take, 32'h12345678);

        // Reset during the mark of bit 10, mark still present at release.
        snap();
        send_bits(32'h3C3C3C3C, 10, 100);
        ir_in = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_cmd", cmd, 32'h0);
        chk("midrst_flags", {28'd0, valid, repeat_det, err, overrun}, 32'h0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        seg(1'b1, 30);
        seg(1'b0, 500);
        chk("midrst_noerr", 32'(n_errp - s_err), 32'd0);

        // All widths stretched by 18 %.
        snap();
        send_frame(32'h807F40BF, 118);
        chk("skew_cmd", last_take, 32'h807F40BF);
        chk("skew_err", 32'(n_errp - s_err), 32'd0);

        // Randomized traffic: jittered frames with random consumer readiness,
        // repeat codes and garbage bursts.
        for (int r = 0; r < 2; r++) begin
            ready = 1'($urandom_range(0, 1));
            send_frame($urandom, $urandom_range(85, 115));
            ready = 1'b1;
            seg(1'b0, 10);
        end
        for (int r = 0; r < 2; r++) begin
            send_repeat($urandom_range(85, 115));
        end
        for (int b = 0; b < 4; b++) begin
            int np;
            np = $urandom_range(1, 5);
            for (int p = 0; p < np; p++) begin
                seg(1'b1, $urandom_range(20, 700));
                seg(1'b0, $urandom_range(20, 700));
            end
            seg(1'b0, 1200);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
